choque_multi: RTL and testbench

Parametrised successor to the single-lane collision checker of the hero game: evaluates the hero pose against a programmable obstacle table in a selectable lane, and keeps lives, pass count and bonus state across a run. It sits between the obstacle display generator (`disp_obs`) and the game-state FSM (`presente`). It reports lose/win on `v_d` and a one-cycle bonus pulse on `bono`.

---
 rtl/choque_multi_if.sv | 49 ++++
 rtl/choque_multi.sv | 174 +++++++++++++++++
 tb/tb_choque_multi.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/choque_multi_if.sv
// Game-side bus of the multi-lane collision checker.
// Bench/game logic drives through master, the checker sits on slave.
interface choque_multi_if #(
  parameter int OBS_W      = 7,
  parameter int POSE_W     = 7,
  parameter int LANES      = 3,
  parameter int NUM_OBS    = 16,
  parameter int MAX_POSES  = 3,
  parameter int LIVES_MAX  = 3,
  parameter int WIN_PASSES = 20
);
  localparam int LSW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW  = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int LVW = $clog2(LIVES_MAX + 1);
  localparam int PSW = $clog2(WIN_PASSES + 1);

  logic                        encendido;
  logic [3:0]                  presente;
  logic [LANES*OBS_W-1:0]      disp_obs;
  logic [LSW-1:0]              lane_sel;
  logic [POSE_W-1:0]           data;
  logic                        eval;
  logic                        tbl_we;
  logic [AW-1:0]               tbl_addr;
  logic [OBS_W-1:0]            tbl_obs;
  logic [MAX_POSES*POSE_W-1:0] tbl_pose;
  logic [MAX_POSES-1:0]        tbl_pvld;
  logic                        tbl_bonus;
  logic                        tbl_vld;
  logic [1:0]                  v_d;
  logic                        bono;
  logic                        hit;
  logic [LVW-1:0]              lives;
  logic [PSW-1:0]              passes;

  modport master (
    output encendido, presente, disp_obs, lane_sel,
    output data, eval, tbl_we, tbl_addr, tbl_obs,
    output tbl_pose, tbl_pvld, tbl_bonus, tbl_vld,
    input  v_d, bono, hit, lives, passes
  );

  modport slave (
    input  encendido, presente, disp_obs, lane_sel,
    input  data, eval, tbl_we, tbl_addr, tbl_obs,
    input  tbl_pose, tbl_pvld, tbl_bonus, tbl_vld,
    output v_d, bono, hit, lives, passes
  );
endinterface

// File: rtl/choque_multi.sv
// Multi-lane hero/obstacle collision checker with a programmable
// obstacle table, lives, pass counting, bonus and grace period.
module choque_multi #(
  parameter int       OBS_W      = 7,
  parameter int       POSE_W     = 7,
  parameter int       LANES      = 3,
  parameter int       NUM_OBS    = 16,
  parameter int       MAX_POSES  = 3,
  parameter int       LIVES_MAX  = 3,
  parameter int       WIN_PASSES = 20,
  parameter int       GRACE_CYC  = 8,
  parameter bit [3:0] JUEGO      = 4'd3,
  parameter bit [3:0] GP         = 4'd4
) (
  input  logic          clk_ob,
  input  logic          rst_n,
  choque_multi_if.slave bus
);
  localparam int LSW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW  = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int LVW = $clog2(LIVES_MAX + 1);
  localparam int PSW = $clog2(WIN_PASSES + 1);
  localparam int GW  = (GRACE_CYC > 0) ? $clog2(GRACE_CYC + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, PLAY, GRACE, LOST, WON
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     v_d_q, v_d_d;
  logic           bono_q, bono_d;
  logic           hit_q, hit_d;
  logic [LVW-1:0] lives_q, lives_d;
  logic [PSW-1:0] passes_q, passes_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;

  logic [OBS_W-1:0]            obs_q   [NUM_OBS];
  logic [MAX_POSES*POSE_W-1:0] pose_q  [NUM_OBS];
  logic [MAX_POSES-1:0]        pvld_q  [NUM_OBS];
  logic                        bonus_q [NUM_OBS];
  logic                        vld_q   [NUM_OBS];

  logic             active;
  logic             tbl_wr;
  logic [OBS_W-1:0] slice;
  logic             lane_ok;
  logic             found;
  logic [AW-1:0]    idx;
  logic             pose_ok;

  always_comb begin
    slice   = '0;
    lane_ok = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (bus.lane_sel == LSW'(l)) begin
        slice   = bus.disp_obs[l*OBS_W +: OBS_W];
        lane_ok = 1'b1;
      end
    end
    // Descending scan so the lowest matching index wins.
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (lane_ok && vld_q[i] && obs_q[i] == slice) begin
        found = 1'b1;
        idx   = AW'(i);
      end
    end
    pose_ok = 1'b0;
    for (int j = 0; j < MAX_POSES; j++) begin
      if (pvld_q[idx][j] &&
          pose_q[idx][j*POSE_W +: POSE_W] == bus.data)
        pose_ok = 1'b1;
    end
  end

  always_comb begin
    active   = bus.encendido &&
               (bus.presente == JUEGO || bus.presente == GP);
    tbl_wr   = bus.tbl_we && state_q == IDLE;
    state_d  = state_q;
    lives_d  = lives_q;
    passes_d = passes_q;
    gcnt_d   = gcnt_q;
    bono_d   = 1'b0;
    hit_d    = 1'b0;
    case (state_q)
      IDLE: begin
        lives_d  = LVW'(LIVES_MAX);
        passes_d = '0;
        if (active) state_d = PLAY;
      end
      PLAY: begin
        if (bus.eval && found) begin
          if (pose_ok) begin
            if (passes_q < PSW'(WIN_PASSES))
              passes_d = passes_q + PSW'(1);
            if (bonus_q[idx]) begin
              bono_d = 1'b1;
              if (lives_q < LVW'(LIVES_MAX))
                lives_d = lives_q + LVW'(1);
            end
            if (passes_q >= PSW'(WIN_PASSES - 1))
              state_d = WON;
          end else begin
            hit_d   = 1'b1;
            lives_d = (lives_q == '0) ? '0 : lives_q - LVW'(1);
            gcnt_d  = '0;
            if (lives_q <= LVW'(1))
              state_d = LOST;
            else if (GRACE_CYC == 0)
              state_d = PLAY;
            else
              state_d = GRACE;
          end
        end
      end
      GRACE: begin
        gcnt_d = gcnt_q + GW'(1);
        if (gcnt_q == GW'(GRACE_CYC - 1)) state_d = PLAY;
      end
      default: ;
    endcase
    if (state_q != IDLE && !active) begin
      state_d  = IDLE;
      lives_d  = LVW'(LIVES_MAX);
      passes_d = '0;
      bono_d   = 1'b0;
      hit_d    = 1'b0;
    end
    v_d_d = (state_d == LOST) ? 2'd1 :
            (state_d == WON)  ? 2'd2 : 2'd0;
  end

  always_ff @(posedge clk_ob or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      v_d_q    <= 2'd0;
      bono_q   <= 1'b0;
      hit_q    <= 1'b0;
      lives_q  <= LVW'(LIVES_MAX);
      passes_q <= '0;
      gcnt_q   <= '0;
      for (int i = 0; i < NUM_OBS; i++) begin
        obs_q[i]   <= '0;
        pose_q[i]  <= '0;
        pvld_q[i]  <= '0;
        bonus_q[i] <= 1'b0;
        vld_q[i]   <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      v_d_q    <= v_d_d;
      bono_q   <= bono_d;
      hit_q    <= hit_d;
      lives_q  <= lives_d;
      passes_q <= passes_d;
      gcnt_q   <= gcnt_d;
      if (tbl_wr) begin
        obs_q[bus.tbl_addr]   <= bus.tbl_obs;
        pose_q[bus.tbl_addr]  <= bus.tbl_pose;
        pvld_q[bus.tbl_addr]  <= bus.tbl_pvld;
        bonus_q[bus.tbl_addr] <= bus.tbl_bonus;
        vld_q[bus.tbl_addr]   <= bus.tbl_vld;
      end
    end
  end

  assign bus.v_d    = v_d_q;
  assign bus.bono   = bono_q;
  assign bus.hit    = hit_q;
  assign bus.lives  = lives_q;
  assign bus.passes = passes_q;
endmodule

// File: tb/tb_choque_multi.sv
// Bench for choque_multi: directed game scenarios plus random play,
// checked every cycle against a rule-level game model.
module tb_choque_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  choque_multi_if bus ();

  choque_multi dut (
    .clk_ob (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bit m_on, m_bono, m_hit;
  int m_lives, m_passes, m_vd, m_grace;
  logic [6:0] t_obs  [16];
  logic [6:0] t_pose [16][3];
  logic [2:0] t_pvld [16];
  bit         t_bonus[16];
  bit         t_vld  [16];

  logic [6:0] pat [6] = '{7'b0001111, 7'b0111000, 7'b1010101,
                          7'b1111111, 7'b1100110, 7'b0000000};
  logic [6:0] pos [5] = '{7'b1000000, 7'b0000001, 7'b0000110,
                          7'b0001000, 7'b0000000};
  logic [6:0] bpose [3] = '{7'b0000001, 7'b1000000, 7'b0000110};

  task automatic check(string name, logic [31:0] got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_bono = 0; m_hit = 0;
    m_lives = 3; m_passes = 0; m_vd = 0; m_grace = 0;
    for (int i = 0; i < 16; i++) t_vld[i] = 0;
  endtask

  task automatic model_step();
    bit act, ok;
    int e;
    logic [6:0] s;
    m_bono = 0;
    m_hit  = 0;
    act = bus.encendido && (bus.presente == 3 || bus.presente == 4);
    if (!m_on) begin
      if (bus.tbl_we) begin
        t_obs[bus.tbl_addr]   = bus.tbl_obs;
        for (int j = 0; j < 3; j++)
          t_pose[bus.tbl_addr][j] = bus.tbl_pose[j*7 +: 7];
        t_pvld[bus.tbl_addr]  = bus.tbl_pvld;
        t_bonus[bus.tbl_addr] = bus.tbl_bonus;
        t_vld[bus.tbl_addr]   = bus.tbl_vld;
      end
      m_lives = 3; m_passes = 0; m_vd = 0; m_grace = 0;
      m_on = act;
    end else if (!act) begin
      m_on = 0; m_lives = 3; m_passes = 0; m_vd = 0;
    end else if (m_vd != 0) begin
      m_grace = 0;
    end else if (m_grace > 0) begin
      m_grace--;
    end else if (bus.eval) begin
      e = -1;
      if (bus.lane_sel < 3) begin
        s = bus.disp_obs[int'(bus.lane_sel)*7 +: 7];
        for (int i = 0; i < 16; i++)
          if (e < 0 && t_vld[i] && t_obs[i] == s) e = i;
      end
      if (e >= 0) begin
        ok = 0;
        for (int j = 0; j < 3; j++)
          if (t_pvld[e][j] && t_pose[e][j] == bus.data) ok = 1;
        if (ok) begin
          m_passes++;
          if (t_bonus[e]) begin
            m_bono = 1;
            if (m_lives < 3) m_lives++;
          end
          if (m_passes == 20) m_vd = 2;
        end else begin
          m_hit = 1;
          m_lives--;
          if (m_lives == 0) m_vd = 1;
          else m_grace = 8;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("v_d", bus.v_d, m_vd);
      check("bono", bus.bono, m_bono);
      check("hit", bus.hit, m_hit);
      check("lives", bus.lives, m_lives);
      check("passes", bus.passes, m_passes);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic ev(logic [6:0] d);
    bus.data = d;
    bus.eval = 1'b1;
    tick();
    bus.eval = 1'b0;
  endtask

  task automatic wr(int a, logic [6:0] o, logic [6:0] p0,
                    logic [6:0] p1, logic [6:0] p2,
                    logic [2:0] pv, bit b, bit v);
    bus.tbl_addr  = 4'(a);
    bus.tbl_obs   = o;
    bus.tbl_pose  = {p2, p1, p0};
    bus.tbl_pvld  = pv;
    bus.tbl_bonus = b;
    bus.tbl_vld   = v;
    bus.tbl_we    = 1'b1;
    tick();
    bus.tbl_we    = 1'b0;
  endtask

  task automatic lane0(logic [6:0] o);
    bus.disp_obs = {14'b0, o};
  endtask

  task automatic load_table();
    wr(0, 7'b0001111, 7'b1000000, 7'd0, 7'd0, 3'b001, 0, 1);
    wr(1, 7'b0111000, bpose[0], bpose[1], bpose[2], 3'b111, 1, 1);
    wr(2, 7'b1010101, 7'b0000001, 7'd0, 7'd0, 3'b001, 0, 1);
    wr(3, 7'b1111111, 7'd0, 7'd0, 7'd0, 3'b000, 0, 1);
    wr(5, 7'b0001111, 7'b0001000, 7'd0, 7'd0, 3'b001, 0, 1);
  endtask

  initial begin
    bus.encendido = 0; bus.presente = 0; bus.disp_obs = '0;
    bus.lane_sel = 0; bus.data = 0; bus.eval = 0;
    bus.tbl_we = 0; bus.tbl_addr = 0; bus.tbl_obs = 0;
    bus.tbl_pose = 0; bus.tbl_pvld = 0; bus.tbl_bonus = 0;
    bus.tbl_vld = 0;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_lives", bus.lives, 3);
    check("rst_passes", bus.passes, 0);
    check("rst_vd", bus.v_d, 0);
    rst_n = 1'b1;
    load_table();

    bus.encendido = 1; bus.presente = 3; bus.lane_sel = 0;
    lane0(7'b0001111);
    tick();
    ev(7'b1000000);
    check("pass_passes", bus.passes, 1);
    check("pass_hit", bus.hit, 0);
    ev(7'b0001000);
    check("hit_pulse", bus.hit, 1);
    check("hit_lives", bus.lives, 2);
    idle(2);
    ev(7'b0001000);
    check("grace_ignore", bus.lives, 2);
    idle(5);
    ev(7'b1000000);
    check("grace_end", bus.passes, 2);

    ev(7'b0001000);
    idle(8);
    ev(7'b0001000);
    check("lose_lives", bus.lives, 0);
    check("lose_vd", bus.v_d, 1);
    ev(7'b1000000);
    check("lost_hold", bus.passes, 2);
    bus.presente = 0;
    tick();
    check("idle_vd", bus.v_d, 0);
    check("idle_lives", bus.lives, 3);

    bus.presente = 3;
    tick();
    ev(7'b0001000);
    idle(8);
    lane0(7'b0111000);
    ev(7'b0000110);
    check("bono_pulse", bus.bono, 1);
    check("bono_lives", bus.lives, 3);
    for (int k = 0; k < 18; k++) ev(bpose[k % 3]);
    check("pre_win", bus.v_d, 0);
    ev(7'b0000001);
    check("win_vd", bus.v_d, 2);
    check("win_passes", bus.passes, 20);

    bus.presente = 0; tick();
    bus.presente = 4; tick();
    bus.disp_obs = {7'b1010101, 14'b0};
    bus.lane_sel = 1;
    ev(7'd0);
    check("lane1_miss", bus.lives, 3);
    bus.lane_sel = 2;
    ev(7'd0);
    check("lane2_hit", bus.lives, 2);

    idle(8);
    wr(0, 7'b1100110, 7'd0, 7'd0, 7'd0, 3'b001, 0, 1);
    bus.lane_sel = 0;
    lane0(7'b1100110);
    ev(7'd0);
    check("we_play_ign", bus.lives, 2);
    lane0(7'b0001111);
    ev(7'b1000000);
    check("entry0_kept", bus.passes, 1);
    lane0(7'b1111111);
    ev(7'd0);
    check("nopose_hit", bus.lives, 1);
    idle(8);
    bus.lane_sel = 3;
    ev(7'd0);
    check("lane3_miss", bus.lives, 1);
    bus.lane_sel = 0;

    lane0(7'b0001111);
    bus.encendido = 0;
    ev(7'b1000000);
    check("drop_wins", bus.passes, 0);
    bus.encendido = 1;
    tick();
    ev(7'b1000000);
    check("replay", bus.passes, 1);

    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_passes", bus.passes, 0);
    check("arst_lives", bus.lives, 3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    ev(7'b1000000);
    check("wiped_pass", bus.passes, 0);
    check("wiped_hit", bus.hit, 0);

    bus.presente = 0; tick();
    load_table();
    bus.presente = 3;
    repeat (3000) begin
      bus.encendido = ($urandom_range(59) != 0);
      case ($urandom_range(29))
        0: bus.presente = 0;
        1: bus.presente = 4'($urandom_range(15));
        2, 3, 4: bus.presente = 4;
        default: bus.presente = 3;
      endcase
      for (int l = 0; l < 3; l++)
        bus.disp_obs[l*7 +: 7] = pat[$urandom_range(5)];
      bus.lane_sel = 2'($urandom_range(3));
      bus.data = ($urandom_range(3) == 0) ? 7'($urandom)
                                           : pos[$urandom_range(4)];
      bus.eval = ($urandom_range(1) == 0);
      bus.tbl_we = ($urandom_range(7) == 0);
      bus.tbl_addr = 4'($urandom_range(15));
      bus.tbl_obs = pat[$urandom_range(5)];
      bus.tbl_pose = {pos[$urandom_range(4)], pos[$urandom_range(4)],
                      pos[$urandom_range(4)]};
      bus.tbl_pvld = 3'($urandom);
      bus.tbl_bonus = 1'($urandom);
      bus.tbl_vld = ($urandom_range(3) != 0);
      tick();
    end
    bus.eval = 0;
    bus.tbl_we = 0;
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
